cw305_reg_initiator: RTL and testbench



---
 rtl/cw305_reg_initiator_if.sv | 52 +++++
 rtl/cw305_reg_initiator.sv | 152 +++++++++++++++
 tb/tb_cw305_reg_initiator.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cw305_reg_initiator_if.sv
// Command, byte-stream and register-bus signals of the CW305 register initiator.
// The slave modport is the initiator's view; master is the client/responder side.
`timescale 1ns/1ps
interface cw305_reg_initiator_if #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [AW-1:0]            cmd_address;
    logic [pBYTECNT_SIZE-1:0] cmd_len;

    logic                     wr_valid;
    logic [7:0]               wr_data;
    logic                     wr_ready;

    logic                     rd_valid;
    logic [7:0]               rd_data;
    logic                     rd_ready;

    logic [AW-1:0]            reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic                     reg_addrvalid;
    logic                     reg_read;
    logic                     reg_write;
    logic [7:0]               write_data;
    logic [7:0]               read_data;

    logic                     busy;
    logic                     done;

    modport slave (
        input  cmd_valid, cmd_write, cmd_address, cmd_len,
        input  wr_valid, wr_data, rd_ready, read_data,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output reg_address, reg_bytecnt, reg_addrvalid,
        output reg_read, reg_write, write_data,
        output busy, done
    );

    modport master (
        output cmd_valid, cmd_write, cmd_address, cmd_len,
        output wr_valid, wr_data, rd_ready, read_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  reg_address, reg_bytecnt, reg_addrvalid,
        input  reg_read, reg_write, write_data,
        input  busy, done
    );
endinterface

// File: rtl/cw305_reg_initiator.sv
// Byte-burst register-bus initiator for the CW305 usb_clk domain.
// Turns read/write burst commands into reg_* strobes with a one-entry read buffer.
`timescale 1ns/1ps
module cw305_reg_initiator #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                  usb_clk,
    input  logic                  reset_i,
    cw305_reg_initiator_if.slave  bus
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int BW = pBYTECNT_SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [AW-1:0] addr_q;
    logic [BW-1:0] len_q;
    logic [BW-1:0] cnt_q;
    logic          dir_q;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;

    logic          last;
    logic          accept;
    logic          cmd_ready_c;
    logic          wr_ready_c;
    logic          reg_read_c;
    logic          reg_write_c;
    logic          addrvalid_c;
    logic [7:0]    wdata_c;
    logic          busy_c;
    logic          done_c;

    assign last   = (cnt_q == len_q);
    assign accept = cmd_ready_c && bus.cmd_valid;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cmd_ready_c = 1'b0;
        wr_ready_c  = 1'b0;
        reg_read_c  = 1'b0;
        reg_write_c = 1'b0;
        addrvalid_c = 1'b0;
        wdata_c     = 8'h00;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy_c      = 1'b0;
                cmd_ready_c = !reset_i;
                if (bus.cmd_valid) begin
                    state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                addrvalid_c = 1'b1;
                state_nx    = dir_q ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                addrvalid_c = 1'b1;
                wr_ready_c  = 1'b1;
                reg_write_c = bus.wr_valid;
                wdata_c     = bus.wr_data;
                if (bus.wr_valid && last) begin
                    state_nx = S_DONE;
                end
            end
            S_READ: begin
                addrvalid_c = 1'b1;
                // Only issue when the buffer is empty or draining this cycle.
                reg_read_c  = !rd_valid_q || bus.rd_ready;
                if (reg_read_c) begin
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                addrvalid_c = 1'b1;
                state_nx    = last ? S_DONE : S_READ;
            end
            S_DONE: begin
                done_c   = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= bus.cmd_address;
                len_q  <= bus.cmd_len;
                dir_q  <= bus.cmd_write;
                cnt_q  <= '0;
            end
            // The counter stops on the last index so reg_bytecnt never wraps.
            if (state == S_WRITE && bus.wr_valid && !last) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state == S_CAPTURE) begin
                rd_data_q  <= bus.read_data;
                rd_valid_q <= 1'b1;
                if (!last) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (rd_valid_q && bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready     = cmd_ready_c;
    assign bus.wr_ready      = wr_ready_c;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.reg_address   = addr_q;
    assign bus.reg_bytecnt   = cnt_q;
    assign bus.reg_addrvalid = addrvalid_c;
    assign bus.reg_read      = reg_read_c;
    assign bus.reg_write     = reg_write_c;
    assign bus.write_data    = wdata_c;
    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
endmodule

// File: tb/tb_cw305_reg_initiator.sv
// Scoreboard bench for cw305_reg_initiator: directed bursts with queued expectations.
// A negedge monitor pops and compares whenever the DUT strobes or hands over a byte.
`timescale 1ns/1ps
module tb_cw305_reg_initiator;
    localparam int AW = 14;
    localparam int BW = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cw305_reg_initiator_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) bus ();

    cw305_reg_initiator #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) dut (
        .usb_clk (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] c;
        logic [7:0]    d;
    } wr_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         n_done = 0;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    int         done_q[$];
    int         rstrb_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not expected / bound expired", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: data is bytecnt ^ 0xA5, valid the cycle after reg_read.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.read_data <= 8'h00;
        else if (bus.reg_read)
            bus.read_data <= {1'b0, bus.reg_bytecnt} ^ 8'hA5;
    end

    wr_t e;
    int  lat;
    always @(negedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) accept_cyc = cyc;
        if (bus.reg_write) begin
            if (wr_q.size() == 0) fail("unexpected_write");
            else begin
                e = wr_q.pop_front();
                chk("wr_addr", 32'(bus.reg_address), 32'(e.a));
                chk("wr_bytecnt", 32'(bus.reg_bytecnt), 32'(e.c));
                chk("wr_data", 32'(bus.write_data), 32'(e.d));
                chk("wr_addrvalid", 32'(bus.reg_addrvalid), 1);
            end
        end
        if (bus.reg_read) begin
            rstrb_q.push_back(cyc);
            chk("rd_one_outstanding", 32'(bus.rd_valid && !bus.rd_ready), 0);
        end
        if (bus.rd_valid && bus.rd_ready) begin
            if (rd_q.size() == 0) fail("unexpected_rd_byte");
            else chk("rd_data", 32'(bus.rd_data), 32'(rd_q.pop_front()));
        end
        if (bus.done) begin
            n_done++;
            if (done_q.size() == 0) fail("unexpected_done");
            else begin
                lat = done_q.pop_front();
                if (lat >= 0) chk("done_latency", 32'(cyc - accept_cyc), 32'(lat));
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                            input logic [BW-1:0] l, input int dl);
        int t;
        done_q.push_back(dl);
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = w;
        bus.cmd_address = a;
        bus.cmd_len     = l;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            t++;
            if (t > 300) begin
                fail("cmd_accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        // Garbage after accept: must be ignored mid-burst.
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = ~w;
        bus.cmd_address = 14'h3FFF;
        bus.cmd_len     = 7'h55;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.done) break;
            t++;
            if (t > 2000) begin
                fail("done_timeout");
                break;
            end
        end
        @(negedge clk);
        chk("cmd_ready_after_done", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int n,
                               input int mul, input int add,
                               input int gap, input int dl);
        int t;
        for (int i = 0; i < n; i++)
            wr_q.push_back(wr_t'{a, 7'(i), 8'(i * mul + add)});
        send_cmd(1'b1, a, 7'(n - 1), dl);
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i * mul + add);
            t = 0;
            while (1) begin
                @(negedge clk);
                if (bus.wr_ready) break;
                t++;
                if (t > 300) begin
                    fail("wr_ready_timeout");
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (i == 0 && gap > 0) begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = 8'hEE;
                repeat (gap) begin
                    @(negedge clk);
                    chk("gap_addrvalid", 32'(bus.reg_addrvalid), 1);
                    chk("gap_bytecnt", 32'(bus.reg_bytecnt), 1);
                end
                @(posedge clk);
                #1;
            end
        end
        bus.wr_valid = 1'b0;
        wait_done();
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int len,
                              input int dl);
        for (int i = 0; i <= len; i++)
            rd_q.push_back(8'(i) ^ 8'hA5);
        send_cmd(1'b0, a, 7'(len), dl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d0;
        int         t;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_address = '0;
        bus.cmd_len     = '0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = 8'h00;
        bus.rd_ready    = 1'b0;
        #1 rst = 1'b1;
        #20;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_addrvalid", 32'(bus.reg_addrvalid), 0);
        chk("rst_strobes", 32'({bus.reg_read, bus.reg_write}), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_address", 32'(bus.reg_address), 0);
        chk("rst_bytecnt", 32'(bus.reg_bytecnt), 0);
        chk("rst_data", 32'({bus.rd_data, bus.write_data}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;

        // 4-byte write, no stalls
        write_burst(14'h000A, 4, 8'h11, 8'h11, 0, 6);

        // 16-byte read, no backpressure
        bus.rd_ready = 1'b1;
        rstrb_q.delete();
        read_burst(14'h0005, 15, 34);
        wait_done();
        chk("rd16_strobes", 32'(rstrb_q.size()), 16);
        for (int i = 1; i < rstrb_q.size(); i++)
            chk("rd16_spacing", 32'(rstrb_q[i] - rstrb_q[i-1]), 2);

        // 3-byte read with backpressure after the first byte
        bus.rd_ready = 1'b0;
        rstrb_q.delete();
        read_burst(14'h0007, 2, -1);
        t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.rd_valid) break;
            t++;
            if (t > 100) begin
                fail("rd_valid_timeout");
                break;
            end
        end
        d0 = bus.rd_data;
        chk("bp_first_byte", 32'(d0), 32'hA5);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(bus.rd_data), 32'(d0));
            chk("bp_hold_valid", 32'(bus.rd_valid), 1);
        end
        chk("bp_single_strobe", 32'(rstrb_q.size()), 1);
        @(posedge clk);
        #1 bus.rd_ready = 1'b1;
        wait_done();
        chk("bp_total_strobes", 32'(rstrb_q.size()), 3);

        // 2-byte write with a 5-cycle wr_valid gap
        write_burst(14'h0123, 2, 8'h69, 8'h5A, 5, -1);

        // 128-byte write, then 1-byte read
        write_burst(14'h1234, 128, 1, 8'h80, 0, 130);
        rstrb_q.delete();
        read_burst(14'h0005, 0, 4);
        wait_done();
        chk("len0_strobes", 32'(rstrb_q.size()), 1);

        // Reset during byte 2 of a 4-byte read
        rstrb_q.delete();
        read_burst(14'h0009, 3, -1);
        t = 0;
        while (1) begin
            @(negedge clk);
            if (bus.reg_read && bus.reg_bytecnt == 7'd1) break;
            t++;
            if (t > 100) begin
                fail("second_read_timeout");
                break;
            end
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_reg_read", 32'(bus.reg_read), 0);
        chk("mid_rst_addrvalid", 32'(bus.reg_addrvalid), 0);
        chk("mid_rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 0);
        rd_q.delete();
        done_q.delete();
        t = n_done;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 32'(n_done - t), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_mid_rst", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        write_burst(14'h000A, 4, 8'h11, 8'h11, 0, 6);

        repeat (5) @(posedge clk);
        #1;
        chk("wr_q_drained", 32'(wr_q.size()), 0);
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        chk("done_q_drained", 32'(done_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
